mac_sequencer: RTL and testbench

- Multi-cycle controller for the shared multiply/multiply-accumulate unit, used by R-type MUL and MAC.
- When the ALU control decode flags a multiply, this block takes the operands and runs an iterative shift-add product over DATA_W cycles.
- For MAC it adds the product into an internal accumulator.
- It stalls the pipeline from the cycle the operation is accepted until the result is ready.

---
 rtl/mac_sequencer.sv | 134 +++++++++++++
 tb/tb_mac_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// mac_sequencer
// Multi-cycle controller for the shared multiply / multiply-accumulate unit
// used by the R-type MUL and MAC instructions. An accepted request runs a
// fixed-latency unsigned shift-add multiply over DATA_W cycles. MAC then adds
// the product into an internal accumulator. The block holds the pipeline
// stalled until the result is ready.
//
// Ports:
//   clk         system clock, rising edge
//   arst_n      asynchronous active-low reset
//   start       request a MUL/MAC (sampled only in IDLE)
//   mac_select  1 = MAC (accumulate), 0 = plain MUL (sampled with start)
//   operand_a   multiplicand (sampled with start)
//   operand_b   multiplier (sampled with start)
//   acc_clear   synchronous accumulator clear, honoured only in IDLE
//   busy        high while the multiply iterates (RUN)
//   stall       pipeline hold request
//   done        one-cycle pulse, result valid
//   result      MUL: low DATA_W bits of product; MAC: updated accumulator
//   acc_value   current accumulator contents
module mac_sequencer #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              mac_select,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              acc_clear,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] acc_value
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  iter_cnt;
  logic [DATA_W-1:0] multiplicand;
  logic [DATA_W-1:0] multiplier;
  logic [DATA_W-1:0] partial;
  logic [DATA_W-1:0] accumulator;
  logic              mac_latched;
  logic [DATA_W-1:0] partial_next;
  logic [DATA_W-1:0] acc_sum;

  // Partial product after the current iteration. On the last RUN edge this
  // value is the complete product, so the result is loaded from here rather
  // than from the partial register.
  always_comb begin
    partial_next = partial;
    if (multiplier[0]) begin
      partial_next = partial + multiplicand;
    end
    acc_sum = accumulator + partial_next;
  end

  // Single FSM holding the datapath registers. In IDLE an acc_clear is
  // written before the start branch. This makes a same-cycle clear+MAC
  // compute 0+product, because the accumulator is only read at the end of
  // RUN.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= IDLE;
      iter_cnt     <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
      partial      <= '0;
      accumulator  <= '0;
      mac_latched  <= 1'b0;
      result       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_clear) begin
            accumulator <= '0;
          end
          if (start) begin
            multiplicand <= operand_a;
            multiplier   <= operand_b;
            mac_latched  <= mac_select;
            partial      <= '0;
            iter_cnt     <= '0;
            state        <= RUN;
          end
        end
        RUN: begin
          partial      <= partial_next;
          multiplicand <= multiplicand << 1;
          multiplier   <= multiplier >> 1;
          iter_cnt     <= iter_cnt + CNT_W'(1);
          // Fixed latency: no early exit even when the multiplier runs out.
          if (iter_cnt == LAST_ITER) begin
            state <= DONE;
            if (mac_latched) begin
              result      <= acc_sum;
              accumulator <= acc_sum;
            end else begin
              result <= partial_next;
            end
          end
        end
        DONE: begin
          // The stalled pipeline still holds start high here. Returning to
          // IDLE unconditionally stops the same instruction being accepted
          // again.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign acc_value = accumulator;

  // The stall drops in DONE so the held instruction retires with the result.
  // It is gated by reset so that it reads 0 while arst_n is low.
  assign stall = arst_n && (((state == IDLE) && start) || (state == RUN));

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer
// Randomised and directed bench for mac_sequencer. It uses an 8-bit instance
// for the bulk of the checks and a default 64-bit instance for the wide case.
// A behavioural model tracks the expected accumulator using plain modular
// arithmetic.
module tb_mac_sequencer;

  localparam int W = 8;

  logic          clk;
  logic          arst_n;
  logic          start;
  logic          mac_select;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic          acc_clear;
  logic          busy;
  logic          stall;
  logic          done;
  logic [W-1:0]  result;
  logic [W-1:0]  acc_value;

  logic          start64;
  logic [63:0]   operand_a64;
  logic [63:0]   operand_b64;
  logic          busy64;
  logic          stall64;
  logic          done64;
  logic [63:0]   result64;
  logic [63:0]   acc_value64;

  int total;
  int bad;
  int acc_model;

  mac_sequencer #(.DATA_W(W)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .start      (start),
    .mac_select (mac_select),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .acc_clear  (acc_clear),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .result     (result),
    .acc_value  (acc_value)
  );

  mac_sequencer dut64 (
    .clk        (clk),
    .arst_n     (arst_n),
    .start      (start64),
    .mac_select (1'b0),
    .operand_a  (operand_a64),
    .operand_b  (operand_b64),
    .acc_clear  (1'b0),
    .busy       (busy64),
    .stall      (stall64),
    .done       (done64),
    .result     (result64),
    .acc_value  (acc_value64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One complete MUL/MAC on the 8-bit instance, checked against the model.
  // Operands are scrambled during RUN to show they were latched. Optionally
  // acc_clear is pulsed mid-RUN, where it must be ignored.
  task automatic applyStimulus(input logic mac, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic clr, input logic mid_clr);
    int cycles;
    int busy_cycles;
    bit got_done;
    int prod;
    int expected;
    @(negedge clk);
    start      = 1'b1;
    mac_select = mac;
    operand_a  = a;
    operand_b  = b;
    acc_clear  = clr;
    #1 checkOutput("stall_on_request", stall, 1);
    prod = (int'(a) * int'(b)) % 256;
    if (clr) acc_model = 0;
    if (mac) begin
      acc_model = (acc_model + prod) % 256;
      expected  = acc_model;
    end else begin
      expected = prod;
    end
    @(negedge clk);
    start      = 1'b0;
    acc_clear  = 1'b0;
    operand_a  = W'($urandom);
    operand_b  = W'($urandom);
    mac_select = ~mac;
    cycles      = 1;
    busy_cycles = 0;
    got_done    = 1'b0;
    while (cycles <= 3 * W && !got_done) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (busy && stall) busy_cycles++;
        acc_clear = (mid_clr && cycles == 3);
        @(negedge clk);
        cycles++;
      end
    end
    acc_clear = 1'b0;
    checkOutput("done_seen", got_done, 1);
    checkOutput("latency", cycles, W + 1);
    checkOutput("busy_cycles", busy_cycles, W);
    checkOutput("stall_in_done", stall, 0);
    checkOutput("busy_in_done", busy, 0);
    checkOutput("result", result, expected);
    checkOutput("acc_value", acc_value, acc_model);
    @(negedge clk);
    checkOutput("done_pulse", done, 0);
    checkOutput("result_hold", result, expected);
  endtask

  initial begin
    int done_times[$];
    int cycles;
    bit got_done;
    logic [63:0] exp64;
    total = 0;
    bad = 0;
    acc_model = 0;
    arst_n = 1'b0;
    start = 1'b1;
    mac_select = 1'b0;
    operand_a = '0;
    operand_b = '0;
    acc_clear = 1'b0;
    start64 = 1'b0;
    operand_a64 = '0;
    operand_b64 = '0;

    // Reset state (start held high to show stall is gated by reset).
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_acc", acc_value, 0);
    start = 1'b0;
    arst_n = 1'b1;

    // Directed scenarios.
    applyStimulus(1'b0, 8'd13, 8'd11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd3, 8'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd5, 8'd6, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd2, 8'd2, 1'b0, 1'b0);
    checkOutput("acc_after_mul", acc_value, 42);
    applyStimulus(1'b1, 8'd16, 8'd16, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd10, 8'd10, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd200, 8'd1, 1'b0, 1'b0);
    checkOutput("wrap_result", result, 44);
    applyStimulus(1'b1, 8'd7, 8'd7, 1'b1, 1'b0);
    checkOutput("clear_mac", result, 49);
    applyStimulus(1'b1, 8'd1, 8'd1, 1'b0, 1'b1);
    checkOutput("mid_clear_ignored", acc_value, 50);

    // start held high: one accept per IDLE visit, dones W+2 apart.
    @(negedge clk);
    start = 1'b1;
    mac_select = 1'b0;
    operand_a = 8'd3;
    operand_b = 8'd5;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        done_times.push_back(i);
        checkOutput("held_result", result, 15);
      end
    end
    start = 1'b0;
    checkOutput("held_done_count", done_times.size(), 3);
    for (int i = 1; i < done_times.size(); i++) begin
      checkOutput("held_spacing", done_times[i] - done_times[i-1], W + 2);
    end
    repeat (W + 3) @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    start = 1'b1;
    mac_select = 1'b1;
    operand_a = 8'd5;
    operand_b = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_stall", stall, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_result", result, 0);
    checkOutput("arst_acc", acc_value, 0);
    acc_model = 0;
    @(negedge clk);
    arst_n = 1'b1;
    applyStimulus(1'b0, 8'd0, 8'd255, 1'b0, 1'b0);

    // Randomised operations.
    for (int n = 0; n < 24; n++) begin
      applyStimulus(1'($urandom), W'($urandom), W'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    // Default-width instance: all-ones times two.
    @(negedge clk);
    start64 = 1'b1;
    operand_a64 = 64'hFFFF_FFFF_FFFF_FFFF;
    operand_b64 = 64'd2;
    exp64 = operand_a64 * operand_b64;
    @(negedge clk);
    start64 = 1'b0;
    operand_a64 = '0;
    cycles = 1;
    got_done = 1'b0;
    while (cycles <= 200 && !got_done) begin
      if (done64) got_done = 1'b1;
      else begin
        @(negedge clk);
        cycles++;
      end
    end
    checkOutput("w64_done_seen", got_done, 1);
    checkOutput("w64_latency", cycles, 65);
    checkOutput("w64_result", result64, exp64);
    checkOutput("w64_result_const", result64, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("w64_acc", acc_value64, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
